// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register for the nand_cpu pipeline.
// Carries an opaque DATA_W-bit payload between adjacent stages, with a synchronous flush.
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry. o_ready is then
// driven from registered state only, with no combinational path from i_ready.
// Without it, the stage holds one entry and o_ready follows i_ready combinationally.

`default_nettype none

module pipe_stage #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [1:0]        o_occupancy
);

  // State is the number of held entries.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic              w_held;
  logic              w_in_xfer;
  logic              w_out_xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_skid_nxt;
`endif

  // Handshake outputs; flush hides both sides so no transfer is counted that cycle.
  always_comb begin
    w_held  = (r_state != ST_EMPTY);
    o_valid = w_held & ~i_flush;
`ifdef PIPE_STAGE_SKID_EN
    // Registered state only: stays ready until the skid entry is occupied.
    o_ready = (r_state != ST_TWO) & ~i_flush & n_rst;
`else
    // Single entry: can take a new word only if it is empty or being drained now.
    o_ready = (~w_held | i_ready) & ~i_flush & n_rst;
`endif
    w_in_xfer   = i_valid & o_ready;
    w_out_xfer  = o_valid & i_ready;
    o_data      = r_main;
    o_occupancy = r_state;
  end

  // Next-state and payload routing; payload registers load only on a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
`ifdef PIPE_STAGE_SKID_EN
    w_skid_nxt  = r_skid;
`endif
    if (i_flush) begin
      // Payloads keep their contents; only the occupancy is dropped.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = i_data;
          end
        end
        ST_ONE: begin
          if (w_in_xfer) begin
            if (w_out_xfer) begin
              w_main_nxt = i_data;
            end else begin
`ifdef PIPE_STAGE_SKID_EN
              // Head stays put; the newer word parks behind it.
              w_state_nxt = ST_TWO;
              w_skid_nxt  = i_data;
`else
              w_state_nxt = ST_ONE;
`endif
            end
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          // No input is accepted here, so the skid word is next in line.
          if (w_out_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
`else
          // Unreachable without the skid entry; recover to a known state.
          w_state_nxt = ST_EMPTY;
`endif
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid register, loaded only when the head is stalled and a new word arrives.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_skid <= '0;
    end else begin
      r_skid <= w_skid_nxt;
    end
  end
`endif

`ifndef SYNTHESIS
  // Occupancy never takes the unused encoding.
  a_state_legal: assert property (@(posedge clk) disable iff (!n_rst)
    r_state != 2'd3);

`ifndef PIPE_STAGE_SKID_EN
  // A single-entry stage never reports two entries.
  a_no_two: assert property (@(posedge clk) disable iff (!n_rst)
    r_state != ST_TWO);
`endif

  // Flush always empties the stage on the next edge.
  a_flush_empties: assert property (@(posedge clk) disable iff (!n_rst)
    i_flush |=> (r_state == ST_EMPTY));

  // A stalled head word must not change under the consumer.
  a_head_stable: assert property (@(posedge clk) disable iff (!n_rst)
    (o_valid && !i_ready && !i_flush) |=> $stable(r_main));
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized and directed bench for pipe_stage against a queue-based model.
// Works for both builds; the model capacity follows PIPE_STAGE_SKID_EN.

module tb_pipe_stage;

  localparam int unsigned W = 32;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_rst;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         i_ready;
  logic         i_flush;
  logic [1:0]   o_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q[$];   // entries the stage must currently hold, head first
  logic [W-1:0] out_log[$];   // words the DUT emitted
  logic [W-1:0] acc_log[$];   // words the DUT accepted

  pipe_stage #(.DATA_W(W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .i_flush    (i_flush),
    .o_occupancy(o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model mid-cycle, advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f,
                      output logic acc);
    logic exp_valid;
    logic exp_ready;
    logic out_x;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    #3;
    exp_valid = (model_q.size() != 0) && !f;
    if (SKID) exp_ready = !f && (model_q.size() < 2);
    else      exp_ready = !f && ((model_q.size() == 0) || r);
    chk("o_valid", 32'(o_valid), 32'(exp_valid));
    chk("o_ready", 32'(o_ready), 32'(exp_ready));
    chk("o_occupancy", 32'(o_occupancy), 32'(model_q.size()));
    if (exp_valid) chk("o_data", o_data, model_q[0]);
    acc   = v && exp_ready;
    out_x = exp_valid && r;
    if (out_x) out_log.push_back(o_data);
    if (acc) acc_log.push_back(d);
    if (f) begin
      model_q.delete();
    end else begin
      if (out_x) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         acc;
    logic [W-1:0] src[$];
    logic         v;
    logic [W-1:0] d;

    n_rst   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    i_flush = 1'b0;

    // Reset state.
    #2;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_occupancy", 32'(o_occupancy), 32'd0);
    #10;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(o_ready), 32'd1);

    // Streaming 1..8 with i_ready held high.
    for (int k = 1; k <= 8; k++) begin
      if (k >= 2) begin
        chk("stream_data", o_data, 32'(k - 1));
        chk("stream_occ", 32'(o_occupancy), 32'd1);
      end
      step(1'b1, W'(k), 1'b1, 1'b0, acc);
    end
    chk("stream_last", o_data, 32'd8);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("stream_drained_occ", 32'(o_occupancy), 32'd0);
    chk("stream_count", 32'(out_log.size()), 32'd8);
    for (int k = 0; k < out_log.size(); k++) chk("stream_order", out_log[k], 32'(k + 1));

    // Stall with downstream not ready, then release.
    out_log.delete();
    src.delete();
    src.push_back(32'h00AA);
    src.push_back(32'h00BB);
    src.push_back(32'h00CC);
    for (int cyc = 0; cyc < 12; cyc++) begin
      v = (src.size() != 0);
      d = v ? src[0] : '0;
      step(v, d, (cyc >= 4), 1'b0, acc);
      if (acc) void'(src.pop_front());
      if (cyc == 1) begin
        chk("stall_occ", 32'(o_occupancy), SKID ? 32'd2 : 32'd1);
        chk("stall_ready", 32'(o_ready), 32'd0);
      end
    end
    chk("stall_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      chk("stall_out0", out_log[0], 32'h00AA);
      chk("stall_out1", out_log[1], 32'h00BB);
      chk("stall_out2", out_log[2], 32'h00CC);
    end

    // Flush while full; the word offered during the flush must never appear.
    step(1'b1, 32'h1234, 1'b0, 1'b0, acc);
    step(1'b1, 32'h5678, 1'b0, 1'b0, acc);
    out_log.delete();
    i_valid = 1'b1;
    i_data  = 32'h9999;
    i_flush = 1'b1;
    #2;
    chk("flush_o_valid", 32'(o_valid), 32'd0);
    chk("flush_o_ready", 32'(o_ready), 32'd0);
    step(1'b1, 32'h9999, 1'b0, 1'b1, acc);
    chk("flush_occ", 32'(o_occupancy), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("flush_no_output", 32'(out_log.size()), 32'd0);

    // Asynchronous reset between clock edges while holding one entry.
    step(1'b1, 32'h4242, 1'b0, 1'b0, acc);
    i_valid = 1'b0;
    #3;
    n_rst = 1'b0;
    #1;
    chk("arst_o_valid", 32'(o_valid), 32'd0);
    chk("arst_o_data", o_data, 32'd0);
    chk("arst_occ", 32'(o_occupancy), 32'd0);
    chk("arst_o_ready", 32'(o_ready), 32'd0);
    model_q.delete();
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", 32'(o_ready), 32'd1);

    // Random valid/ready at 50% each; scoreboard the full sequence afterwards.
    out_log.delete();
    acc_log.delete();
    for (int k = 0; k < 10000; k++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc);
    end
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("sb_count", 32'(out_log.size()), 32'(acc_log.size()));
    for (int k = 0; k < out_log.size() && k < acc_log.size(); k++) begin
      chk("sb_order", out_log[k], acc_log[k]);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
